fifo_tx_arbiter: RTL and testbench

FIFO_TX_ARBITER -- requirements
Module: fifo_tx_arbiter

---
 rtl/fifo_tx_arbiter.sv | 125 ++++++++++++
 tb/tb_fifo_tx_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_tx_arbiter.sv
// ============================================================================
// Module      : fifo_tx_arbiter
// Description : Round-robin arbiter that feeds one requester at a time into a
//               fifo through a tx_rdy / tx_done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fifo_tx_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int GNT_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_rdy,
    input  logic [WIDTH*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_done,
    output logic                     tx_rdy,
    input  logic                     tx_done,
    output logic [WIDTH-1:0]         tx_data,
    output logic [GNT_WIDTH-1:0]     grant,
    output logic                     busy,
    output logic [15:0]              xfer_count
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SEND    = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    localparam logic [GNT_WIDTH-1:0] C_LAST_RST = GNT_WIDTH'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0]   C_ONE      = NUM_REQ'(1);

    logic [1:0]           r_state;
    logic [GNT_WIDTH-1:0] r_last;
    logic [GNT_WIDTH-1:0] r_grant;
    logic [WIDTH-1:0]     r_tx_data;
    logic [NUM_REQ-1:0]   r_req_done;
    logic                 r_tx_rdy;
    logic                 r_busy;
    logic [15:0]          r_xfer_count;

    logic                 w_any_req;
    logic [GNT_WIDTH-1:0] w_winner;
    logic                 w_release_ok;
    logic [15:0]          w_xfer_nxt;

    // Search downward so the requester closest after r_last is written last and wins.
    always_comb begin
        w_any_req = |req_rdy;
        w_winner  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_rdy[(int'(r_last) + k) % NUM_REQ]) begin
                w_winner = GNT_WIDTH'((int'(r_last) + k) % NUM_REQ);
            end
        end
    end

    assign w_release_ok = !tx_done && !req_rdy[r_grant];

    always_comb begin
        w_xfer_nxt = r_xfer_count;
        if (r_state == S_RELEASE && w_release_ok) begin
            w_xfer_nxt = 16'(r_xfer_count + 16'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last       <= C_LAST_RST;
            r_grant      <= '0;
            r_tx_data    <= '0;
            r_req_done   <= '0;
            r_tx_rdy     <= 1'b0;
            r_busy       <= 1'b0;
            r_xfer_count <= 16'd0;
        end else begin
            r_xfer_count <= w_xfer_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant   <= w_winner;
                        r_tx_data <= req_data[w_winner*WIDTH +: WIDTH];
                        r_tx_rdy  <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (tx_done) begin
                        r_tx_rdy   <= 1'b0;
                        r_req_done <= C_ONE << r_grant;
                        r_state    <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (w_release_ok) begin
                        r_req_done <= '0;
                        r_last     <= r_grant;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_tx_rdy   <= 1'b0;
                    r_req_done <= '0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign req_done   = r_req_done;
    assign tx_rdy     = r_tx_rdy;
    assign tx_data    = r_tx_data;
    assign grant      = r_grant;
    assign busy       = r_busy;
    assign xfer_count = r_xfer_count;

endmodule

`default_nettype wire

// File: tb/tb_fifo_tx_arbiter.sv
// ============================================================================
// Module      : tb_fifo_tx_arbiter
// Description : Directed self-checking bench for fifo_tx_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fifo_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_rdy;
    logic [31:0] req_data;
    logic [3:0]  req_done;
    logic        tx_rdy;
    logic        tx_done;
    logic [7:0]  tx_data;
    logic [1:0]  grant;
    logic        busy;
    logic [15:0] xfer_count;

    int n_checks = 0;
    int n_errors = 0;
    int n_viol   = 0;

    always #5 clk = ~clk;

    fifo_tx_arbiter #(
        .WIDTH     (8),
        .NUM_REQ   (4),
        .GNT_WIDTH (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_rdy    (req_rdy),
        .req_data   (req_data),
        .req_done   (req_done),
        .tx_rdy     (tx_rdy),
        .tx_done    (tx_done),
        .tx_data    (tx_data),
        .grant      (grant),
        .busy       (busy),
        .xfer_count (xfer_count)
    );

    // Handshake invariants watched on every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_rdy && (req_done != 4'b0000)) n_viol++;
            if ($countones(req_done) > 1) n_viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_tx_rdy(input string tag);
        for (int i = 0; i < 20 && !tx_rdy; i++) @(negedge clk);
        check({tag, "_tx_rdy"}, 32'(tx_rdy), 32'd1);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        tx_done = 1'b0;
        req_rdy = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One complete transfer: grant seen, fifo accepts after 'hold' cycles, requester withdraws.
    task automatic serve(input string tag, input int exp_g, input logic [7:0] exp_d, input int hold);
        wait_tx_rdy(tag);
        check({tag, "_grant"}, 32'(grant), 32'(exp_g));
        check({tag, "_data"}, 32'(tx_data), 32'(exp_d));
        repeat (hold) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        check({tag, "_req_done"}, 32'(req_done), 32'(4'b0001 << exp_g));
        check({tag, "_tx_rdy_low"}, 32'(tx_rdy), 32'd0);
        tx_done        = 1'b0;
        req_rdy[exp_g] = 1'b0;
        @(negedge clk);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int seq [6] = '{0, 1, 2, 3, 0, 1};
        int ok;

        rst_n    = 1'b0;
        tx_done  = 1'b0;
        req_rdy  = 4'b0000;
        req_data = {8'h44, 8'h33, 8'hA5, 8'h11};
        #2;
        check("rst_tx_rdy", 32'(tx_rdy), 32'd0);
        check("rst_req_done", 32'(req_done), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_xfer", 32'(xfer_count), 32'd0);
        do_reset();

        // Single request from requester 1
        req_rdy = 4'b0010;
        @(negedge clk);
        check("single_tx_rdy_1cyc", 32'(tx_rdy), 32'd1);
        check("single_busy", 32'(busy), 32'd1);
        serve("single", 1, 8'hA5, 1);
        check("single_xfer", 32'(xfer_count), 32'd1);

        // All requesters active, each re-raises after its acknowledge
        do_reset();
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req_rdy  = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            serve($sformatf("rr%0d", i), seq[i], 8'(8'h11 * (seq[i] + 1)), 0);
            req_rdy[seq[i]] = 1'b1;
        end
        req_rdy = 4'b0000;
        check("rr_xfer", 32'(xfer_count), 32'd6);

        // Fifo full: tx_done held low for 50 cycles
        req_rdy = 4'b0001;
        wait_tx_rdy("bp");
        ok = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_rdy && busy && req_done == 4'b0000) ok++;
        end
        check("bp_hold", 32'(ok), 32'd50);
        tx_done = 1'b1;
        @(negedge clk);
        check("bp_req_done", 32'(req_done), 32'b0001);
        tx_done = 1'b0;
        req_rdy = 4'b0000;
        @(negedge clk);
        check("bp_xfer", 32'(xfer_count), 32'd7);

        // Requester 2 withdraws during SEND
        req_data[23:16] = 8'h5C;
        req_rdy         = 4'b0100;
        wait_tx_rdy("wd");
        check("wd_grant", 32'(grant), 32'd2);
        check("wd_data", 32'(tx_data), 32'h5C);
        req_rdy         = 4'b0000;
        req_data[23:16] = 8'hFF;
        repeat (2) @(negedge clk);
        check("wd_data_held", 32'(tx_data), 32'h5C);
        check("wd_tx_rdy_held", 32'(tx_rdy), 32'd1);
        tx_done = 1'b1;
        @(negedge clk);
        check("wd_req_done", 32'(req_done), 32'b0100);
        tx_done = 1'b0;
        @(negedge clk);
        check("wd_xfer", 32'(xfer_count), 32'd8);
        check("wd_idle", 32'(busy), 32'd0);

        // Asynchronous reset pulse while in RELEASE
        req_rdy = 4'b0010;
        wait_tx_rdy("mr");
        tx_done = 1'b1;
        @(negedge clk);
        check("mr_in_release", 32'(req_done), 32'b0010);
        #1 rst_n = 1'b0;
        #1;
        check("mr_tx_rdy", 32'(tx_rdy), 32'd0);
        check("mr_req_done", 32'(req_done), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_xfer", 32'(xfer_count), 32'd0);
        req_rdy = 4'b0000;
        tx_done = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        req_rdy = 4'b1001;
        serve("mr_after", 0, 8'h11, 0);
        req_rdy = 4'b0000;
        check("mr_after_xfer", 32'(xfer_count), 32'd1);

        // Counter wrap from 0xFFFF
        force dut.r_xfer_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_xfer_count;
        check("wrap_preload", 32'(xfer_count), 32'hFFFF);
        req_rdy = 4'b1000;
        serve("wrap", 3, 8'h44, 0);
        check("wrap_xfer", 32'(xfer_count), 32'h0000);

        check("invariants", 32'(n_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
